// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer: commit-trace capture for the pipelined CPU.
// Logs each enabled register write as {cycle, pc, rd, data} into a FWFT FIFO
// drained by valid/ready, and raises halted once the fetch pc stops moving.
module pipe_trace_buffer #(
  parameter int          DATA_W      = 64,
  parameter int          PC_W        = 64,
  parameter int          CYC_W       = 32,
  parameter int          DEPTH       = 16,
  parameter int          WRAP_MODE   = 0,
  parameter logic [31:0] REG_MASK    = 32'hFFFF_FFFE,
  parameter int          STALL_LIMIT = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            arm,
  input  logic                            clear,
  input  logic                            wb_valid,
  input  logic [4:0]                      wb_rd,
  input  logic [DATA_W-1:0]               wb_data,
  input  logic [PC_W-1:0]                 wb_pc,
  input  logic [PC_W-1:0]                 cur_pc,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic [CYC_W+PC_W+5+DATA_W-1:0]  rd_data,
  output logic [$clog2(DEPTH):0]          count,
  output logic                            overflow,
  output logic                            halted,
  output logic [CYC_W-1:0]                cycle
);

  localparam int EW = CYC_W + PC_W + 5 + DATA_W;
  localparam int AW = $clog2(DEPTH);
  // wide enough for 0..STALL_LIMIT, and at least one bit when halt detect is off
  localparam int SW = $clog2(STALL_LIMIT + 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAP  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]      state;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [EW-1:0]   mem [DEPTH];
  logic [PC_W-1:0] pc_q;
  logic [SW-1:0]   stall, stall_nxt;
  logic            push_req, pop, full, do_write, head_adv;

  // capture/pop qualification; a full non-wrapping FIFO only accepts a push alongside a pop
  always_comb begin
    push_req  = (state == S_CAP) && wb_valid && (wb_rd != 5'd0) && REG_MASK[wb_rd];
    pop       = (count != '0) && rd_ready;
    full      = (count == (AW+1)'(DEPTH));
    do_write  = push_req && !clear && (!full || pop || (WRAP_MODE != 0));
    // head also moves when a wrapping push overwrites the oldest entry
    head_adv  = pop || (do_write && full);
    stall_nxt = (cur_pc == pc_q) ? stall + SW'(1) : '0;
  end

  // read side is first-word-fall-through; data forced to 0 while empty
  always_comb begin
    rd_valid = (count != '0);
    rd_data  = rd_valid ? mem[rd_ptr] : '0;
    halted   = (state == S_HALT);
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (head_adv) rd_ptr <= rd_ptr + AW'(1);
      if (do_write && !head_adv)      count <= count + (AW+1)'(1);
      else if (head_adv && !do_write) count <= count - (AW+1)'(1);
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  // trace storage, not reset; stamp is the cycle value before this edge's increment
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= {cycle, wb_pc, wb_rd, wb_data};
  end

  // run-state FSM, cycle counter and pc-stall halt detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cycle <= '0;
      stall <= '0;
      pc_q  <= '0;
    end else begin
      // sampled in every state so the first capture cycle compares against the idle sample
      pc_q <= cur_pc;
      if (clear) begin
        state <= S_IDLE;
        cycle <= '0;
        stall <= '0;
      end else begin
        case (state)
          S_IDLE: if (arm) state <= S_CAP;
          S_CAP: begin
            if (cycle != {CYC_W{1'b1}}) cycle <= cycle + CYC_W'(1);
            if (STALL_LIMIT != 0) begin
              stall <= stall_nxt;
              if (stall_nxt == SW'(STALL_LIMIT)) state <= S_HALT;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb_pipe_trace_buffer: four differently parameterised instances share one
// stimulus stream; a list-based reference model predicts every output each cycle.
module tb_pipe_trace_buffer;

  localparam int NI = 4;
  localparam int DW = 64;
  localparam int PW = 64;
  // per-instance parameters, index 0 is the rightmost element
  localparam logic [NI-1:0][31:0] DEP  = {32'd2, 32'd8, 32'd4, 32'd4};
  localparam logic [NI-1:0][31:0] WRP  = {32'd0, 32'd1, 32'd1, 32'd0};
  localparam logic [NI-1:0][31:0] MSK  = {32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h0000_0006, 32'hFFFF_FFFE};
  localparam logic [NI-1:0][31:0] SLIM = {32'd0, 32'd3, 32'd8, 32'd8};
  localparam logic [NI-1:0][31:0] CW   = {32'd32, 32'd4, 32'd32, 32'd32};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        arm = 1'b0, clear = 1'b0, wb_valid = 1'b0, rd_ready = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [63:0] wb_data = '0, wb_pc = '0, cur_pc = 64'h1000;
  logic        pc_run = 1'b0;

  logic [NI-1:0]          rdv, ovf, hlt;
  logic [NI-1:0][255:0]   rdd;
  logic [NI-1:0][31:0]    cnt, cyco;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int CWG = int'(CW[g]);
    localparam int AWG = $clog2(int'(DEP[g]));
    logic [CWG+PW+5+DW-1:0] d;
    logic [AWG:0]           c;
    logic [CWG-1:0]         cy;
    pipe_trace_buffer #(
      .DATA_W(DW), .PC_W(PW), .CYC_W(CWG), .DEPTH(int'(DEP[g])),
      .WRAP_MODE(int'(WRP[g])), .REG_MASK(MSK[g]), .STALL_LIMIT(int'(SLIM[g]))
    ) u_dut (
      .clk(clk), .reset(reset), .arm(arm), .clear(clear),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc),
      .cur_pc(cur_pc), .rd_valid(rdv[g]), .rd_ready(rd_ready), .rd_data(d),
      .count(c), .overflow(ovf[g]), .halted(hlt[g]), .cycle(cy)
    );
    assign rdd[g]  = 256'(d);
    assign cnt[g]  = 32'(c);
    assign cyco[g] = 32'(cy);
  end

  // reference model: list with oldest entry at index 0; state 0 idle, 1 capture, 2 halted
  int           m_st [NI];
  int           m_n  [NI];
  logic [255:0] m_q  [NI][16];
  logic [31:0]  m_cyc [NI];
  int           m_stall [NI];
  logic [63:0]  m_prev [NI];
  logic         m_ovf [NI];

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic shift_out(input int i);
    for (int k = 0; k < 15; k++) m_q[i][k] = m_q[i][k+1];
    m_n[i]--;
  endtask

  // advance the model across the coming clock edge using the inputs now applied
  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      logic pop, push;
      logic [255:0] e;
      logic [31:0] cmax;
      if (!reset) begin
        m_st[i] = 0; m_n[i] = 0; m_cyc[i] = 0; m_stall[i] = 0; m_prev[i] = '0; m_ovf[i] = 1'b0;
      end else begin
        cmax = 32'((64'd1 << CW[i]) - 64'd1);
        pop  = (m_n[i] != 0) && rd_ready;
        push = (m_st[i] == 1) && wb_valid && (wb_rd != 5'd0) && MSK[i][wb_rd];
        e = (256'(m_cyc[i]) << (PW + 5 + DW)) | (256'(wb_pc) << (5 + DW)) |
            (256'(wb_rd) << DW) | 256'(wb_data);
        if (clear) begin
          m_st[i] = 0; m_n[i] = 0; m_cyc[i] = 0; m_stall[i] = 0; m_ovf[i] = 1'b0;
        end else begin
          if (pop) shift_out(i);
          if (push) begin
            if (m_n[i] < int'(DEP[i])) begin
              m_q[i][m_n[i]] = e; m_n[i]++;
            end else if (WRP[i] != 0) begin
              shift_out(i); m_q[i][m_n[i]] = e; m_n[i]++; m_ovf[i] = 1'b1;
            end else begin
              m_ovf[i] = 1'b1;
            end
          end
          if (m_st[i] == 0) begin
            if (arm) m_st[i] = 1;
          end else if (m_st[i] == 1) begin
            if (m_cyc[i] != cmax) m_cyc[i] = m_cyc[i] + 1;
            if (SLIM[i] != 0) begin
              m_stall[i] = (cur_pc == m_prev[i]) ? m_stall[i] + 1 : 0;
              if (m_stall[i] == int'(SLIM[i])) m_st[i] = 2;
            end
          end
        end
        m_prev[i] = cur_pc;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("count%0d", i), 256'(cnt[i]), 256'(m_n[i]));
      chk($sformatf("rd_valid%0d", i), 256'(rdv[i]), 256'(m_n[i] != 0));
      chk($sformatf("rd_data%0d", i), rdd[i], (m_n[i] != 0) ? m_q[i][0] : 256'd0);
      chk($sformatf("overflow%0d", i), 256'(ovf[i]), 256'(m_ovf[i]));
      chk($sformatf("halted%0d", i), 256'(hlt[i]), 256'(m_st[i] == 2));
      chk($sformatf("cycle%0d", i), 256'(cyco[i]), 256'(m_cyc[i]));
    end
  endtask

  task automatic tick();
    if (pc_run) cur_pc = cur_pc + 64'd4;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic commit(input logic [4:0] rd, input logic [63:0] data);
    wb_valid = 1'b1; wb_rd = rd; wb_data = data; wb_pc = cur_pc;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic restart();
    clear = 1'b1; tick(); clear = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [4:0]  rds [5];
    logic [63:0] dts [5];
    logic [31:0] saved;
    int n;
    rds = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
    dts = '{64'd1, 64'd1, 64'd2, 64'd3, 64'd5};

    // reset state
    repeat (2) tick();
    chk("rst_count", 256'(cnt[0]), 256'd0);
    chk("rst_valid", 256'(rdv[0]), 256'd0);
    chk("rst_data", rdd[0], 256'd0);
    chk("rst_halted", 256'(hlt[0]), 256'd0);
    reset = 1'b1; pc_run = 1'b1;
    tick();

    // fibonacci commits x1..x5, stamps 0..4
    arm = 1'b1; tick(); arm = 1'b0;
    for (int k = 0; k < 5; k++) commit(rds[k], dts[k]);
    chk("mask_count", 256'(cnt[1]), 256'd2);
    chk("nowrap_ovf", 256'(ovf[0]), 256'd1);
    for (int k = 0; k < 5; k++) begin
      chk("fib_stamp", 256'(rdd[2][136:133]), 256'(k));
      chk("fib_rd", 256'(rdd[2][68:64]), 256'(rds[k]));
      chk("fib_data", 256'(rdd[2][63:0]), 256'(dts[k]));
      rd_ready = 1'b1; tick();
    end
    chk("fib_empty", 256'(rdv[2]), 256'd0);
    rd_ready = 1'b0;

    // six pushes into depth 4: drop newest vs overwrite oldest
    restart();
    for (int k = 1; k <= 6; k++) commit(5'((k % 2) + 1), 64'(k));
    chk("nowrap_cnt", 256'(cnt[0]), 256'd4);
    chk("nowrap_head", 256'(rdd[0][63:0]), 256'd1);
    chk("wrap_cnt", 256'(cnt[1]), 256'd4);
    chk("wrap_head", 256'(rdd[1][63:0]), 256'd3);
    chk("wrap_ovf", 256'(ovf[1]), 256'd1);

    // full FIFO, push and pop together
    restart();
    for (int k = 1; k <= 4; k++) commit(5'((k % 2) + 1), 64'(k));
    chk("pp_head0", 256'(rdd[0][63:0]), 256'd1);
    rd_ready = 1'b1;
    commit(5'd2, 64'd5);
    rd_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("pp_cnt", 256'(cnt[i]), 256'd4);
      chk("pp_ovf", 256'(ovf[i]), 256'd0);
      chk("pp_head", 256'(rdd[i][63:0]), 256'd2);
    end

    // reset mid-capture with 5 entries held
    restart();
    for (int k = 0; k < 5; k++) commit(rds[k], dts[k]);
    reset = 1'b0; tick();
    chk("midrst_cnt", 256'(cnt[2]), 256'd0);
    chk("midrst_valid", 256'(rdv[2]), 256'd0);
    chk("midrst_cycle", 256'(cyco[2]), 256'd0);
    reset = 1'b1; tick();

    // halt detect: freeze first sampled on one edge, then 8 equal samples halt instance 0
    arm = 1'b1; tick(); arm = 1'b0;
    for (int k = 0; k < 3; k++) commit(5'(k + 1), 64'(k + 100));
    pc_run = 1'b0; cur_pc = 64'h40;
    wb_valid = 1'b1; wb_rd = 5'd7; wb_pc = 64'h3c; wb_data = 64'd77;
    tick();
    n = 0;
    while (!hlt[0] && n < 20) begin
      wb_rd = 5'($urandom_range(0, 31)); wb_data = 64'($urandom);
      tick(); n++;
    end
    chk("halt_latency", 256'(n), 256'd8);
    wb_valid = 1'b0;
    saved = cyco[0];
    repeat (3) tick();
    chk("halt_cycle_hold", 256'(cyco[0]), 256'(saved));
    rd_ready = 1'b1;
    repeat (10) tick();
    chk("drain_valid", 256'(rdv[0]), 256'd0);
    rd_ready = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear_halted", 256'(hlt[0]), 256'd0);

    // randomized traffic
    arm = 1'b1; tick(); arm = 1'b0;
    for (int t = 0; t < 500; t++) begin
      if ($urandom_range(0, 7) != 0) cur_pc = cur_pc + 64'd4;
      arm      = ($urandom_range(0, 15) == 0);
      clear    = ($urandom_range(0, 79) == 0);
      reset    = ($urandom_range(0, 249) != 0);
      wb_valid = $urandom_range(0, 1) == 1;
      wb_rd    = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      wb_data  = {32'($urandom), 32'($urandom)};
      wb_pc    = cur_pc - 64'd16;
      rd_ready = $urandom_range(0, 2) != 0;
      if (t >= 200 && t < 260) cur_pc = 64'h80;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
